// File: rtl/piso_serializer.sv
// Parallel-in serial-out shifter, MSB first, valid/ready load side.
// Optional even-parity trailer bit compiled in with PISO_PARITY_EN.
module piso_serializer #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             SYNC_RESET_N,
    input  logic [WIDTH-1:0] DIN,
    input  logic             DIN_VALID,
    output logic             DIN_READY,
    output logic             SOUT,
    output logic             SOUT_VALID,
    output logic             FRAME_START,
    output logic             DONE
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

`ifdef PISO_PARITY_EN
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_t;
`else
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;
`endif

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] sreg;
    logic [CW-1:0]    cnt;
    logic             load;
    logic             last_bit;
`ifdef PISO_PARITY_EN
    logic             par;
`endif

    assign load     = DIN_VALID && DIN_READY;
    assign last_bit = (state == SHIFT) && (cnt == LAST);

    // State register
    always_ff @(posedge CLK) begin
        if (!SYNC_RESET_N) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (load) state_nxt = SHIFT;
            end
            SHIFT: begin
                if (last_bit) begin
`ifdef PISO_PARITY_EN
                    state_nxt = PARITY;
`else
                    state_nxt = load ? SHIFT : IDLE;
`endif
                end
            end
`ifdef PISO_PARITY_EN
            PARITY: begin
                state_nxt = load ? SHIFT : IDLE;
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

    // Shift register, bit counter and parity capture
    always_ff @(posedge CLK) begin
        if (!SYNC_RESET_N) begin
            sreg <= '0;
            cnt  <= '0;
`ifdef PISO_PARITY_EN
            par  <= 1'b0;
`endif
        end else if (load) begin
            sreg <= DIN;
            cnt  <= '0;
`ifdef PISO_PARITY_EN
            par  <= ^DIN;
`endif
        end else if (state == SHIFT) begin
            sreg <= sreg << 1;
            cnt  <= cnt + CW'(1);
        end
    end

    // Output decode from state
    always_comb begin
        DIN_READY   = 1'b0;
        SOUT        = 1'b0;
        SOUT_VALID  = 1'b0;
        FRAME_START = 1'b0;
        DONE        = 1'b0;
        unique case (state)
            IDLE: begin
                DIN_READY = 1'b1;
            end
            SHIFT: begin
                SOUT        = sreg[WIDTH-1];
                SOUT_VALID  = 1'b1;
                FRAME_START = (cnt == '0);
`ifndef PISO_PARITY_EN
                DIN_READY   = last_bit;
                DONE        = last_bit;
`endif
            end
`ifdef PISO_PARITY_EN
            PARITY: begin
                SOUT       = par;
                SOUT_VALID = 1'b1;
                DIN_READY  = 1'b1;
                DONE       = 1'b1;
            end
`endif
            default: begin
                DIN_READY = 1'b0;
            end
        endcase
    end

endmodule

// File: doc/piso_serializer.md
PISO_SERIALIZER -- requirements
Module: piso_serializer

Interface
REQ-001 SHALL have parameter WIDTH, default 8, parallel word width in bits (legal range 2..32).
REQ-002 SHALL have port CLK  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port SYNC_RESET_N  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port DIN  input  WIDTH  parallel word to serialize.
REQ-005 SHALL have port DIN_VALID  input  1  DIN holds a word to load.
REQ-006 SHALL have port DIN_READY  output  1  block can accept a word this cycle.
REQ-007 SHALL have port SOUT  output  1  serial data bit, MSB first.
REQ-008 SHALL have port SOUT_VALID  output  1  SOUT carries a frame bit this cycle.
REQ-009 SHALL have port FRAME_START  output  1  one-cycle pulse with the first bit (MSB) of each frame.
REQ-010 SHALL have port DONE  output  1  one-cycle pulse with the last bit of each frame.

Function
REQ-011 SHALL implement states IDLE and SHIFT, plus PARITY when PARITY_EN is defined.
REQ-012 SHALL load DIN when DIN_VALID and DIN_READY are both 1 at a rising edge; no other condition loads.
REQ-013 SHALL drive DIN_READY=1 in IDLE and during the last bit cycle of a frame; 0 otherwise (combinational from state).
REQ-014 SHALL present DIN[WIDTH-1] on SOUT with SOUT_VALID=1 and FRAME_START=1 in the cycle after the load edge (latency 1).
REQ-015 SHALL present DIN[WIDTH-1-k] on SOUT in the k-th cycle after the first bit, for k = 1..WIDTH-1.
REQ-016 SHALL use a bit counter of ceil(log2(WIDTH+1)) bits; the counter resets to 0 on load and never wraps mid-frame.
REQ-017 SHALL, without PARITY_EN, assert DONE with bit DIN[0]; with PARITY_EN, assert DONE with the parity bit.
REQ-018 SHALL, when a load occurs in the last bit cycle, start the next frame in the immediately following cycle (zero-gap back-to-back).
REQ-019 SHALL return to IDLE after the last bit if no load occurred, driving SOUT=0, SOUT_VALID=0, FRAME_START=0, DONE=0.
REQ-020 SHALL ignore DIN and DIN_VALID while DIN_READY=0; the captured word is not affected by DIN changes after the load.
REQ-021 SHALL hold SOUT=0 whenever SOUT_VALID=0.

Reset
REQ-022 SHALL, when SYNC_RESET_N=0 at a rising edge, enter IDLE, clear the shift register and counter, and abort any frame in progress without emitting DONE.
REQ-023 SHALL have reset values DIN_READY=1 (IDLE), SOUT=0, SOUT_VALID=0, FRAME_START=0, DONE=0.
REQ-024 SHALL give reset priority over a simultaneous load; a word offered in the reset cycle is dropped.
REQ-025 SHALL not respond to SYNC_RESET_N between clock edges.

Configuration
REQ-026 SHALL use macro PISO_PARITY_EN to compile in the parity stage.
REQ-027 SHALL, with PISO_PARITY_EN defined, append one bit equal to the XOR of all WIDTH data bits (even parity) after DIN[0]; frame length WIDTH+1 cycles.
REQ-028 SHALL, with PISO_PARITY_EN undefined, contain no PARITY state or parity logic; frame length WIDTH cycles.

Verification
REQ-029 SHALL verify: WIDTH=8, no parity, load 0xA5 -> SOUT 1,0,1,0,0,1,0,1 on 8 consecutive cycles; FRAME_START on the 1st, DONE on the 8th, then IDLE.
REQ-030 SHALL verify: PISO_PARITY_EN, load 0x07 -> 0,0,0,0,0,1,1,1 then parity 1; DONE on the 9th bit; load 0xA5 -> parity bit 0.
REQ-031 SHALL verify: 0xA5 then 0x3C offered with DIN_VALID held -> 16 contiguous SOUT_VALID cycles, second FRAME_START immediately after the first DONE.
REQ-032 SHALL verify: SYNC_RESET_N=0 during the 4th bit of 0xA5 -> next cycle SOUT_VALID=0, DONE never pulses, DIN_READY=1.
REQ-033 SHALL verify: DIN changed to 0xFF and DIN_VALID held mid-frame of 0x81 -> output stays 1,0,0,0,0,0,0,1; 0xFF loads only in the last bit cycle.
REQ-034 SHALL verify: DIN_VALID=1 with SYNC_RESET_N=0 on the same edge -> no frame starts; the first frame begins only after a load with reset released.
